// File: rtl/puf_ctrl_pkg.sv
// rtl/puf_ctrl_pkg.sv - shared types and constants for the RO-PUF evaluation sequencer
package puf_ctrl_pkg;

    localparam int NUM_OSC   = 32;
    localparam int SEL_W     = 5;
    localparam int CLEAR_CYC = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_COUNT,
        S_SYNC,
        S_COMPARE,
        S_DONE
    } puf_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/puf_phase_timer.sv
// rtl/puf_phase_timer.sv - loadable down-counter timing each measurement phase
module puf_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Loaded with (phase length - 1) so expire marks the last cycle of the phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/puf_eval_sequencer.sv
// rtl/puf_eval_sequencer.sv - measurement scheduler producing a multi-bit RO-PUF response
module puf_eval_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int RESP_BITS  = 8,
    parameter int CNT_W      = 16,
    parameter int WINDOW_CYC = 256,
    parameter int SETTLE_CYC = 16,
    parameter int SYNC_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     chal_a,
    input  logic [SEL_W-1:0]     chal_b,
    output logic                 busy,
    output logic                 cfg_err,
    output logic                 osc_en,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    input  logic [CNT_W-1:0]     cnt_a,
    input  logic [CNT_W-1:0]     cnt_b,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 tie_seen
);

    localparam int MAX_PH = max_int(max_int(WINDOW_CYC, SETTLE_CYC), max_int(SYNC_CYC, CLEAR_CYC));
    localparam int TW     = $clog2(MAX_PH);
    localparam int KW     = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    puf_state_t    state, next_state;
    logic          load;
    logic [TW-1:0] load_val;
    logic          expire;
    logic [KW-1:0] k;
    logic          accept;
    logic          reject;
    logic          last_bit;

    puf_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    assign last_bit = (k == KW'(RESP_BITS - 1));
    assign busy     = (state != S_IDLE);

    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        accept     = 1'b0;
        reject     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && (chal_a != chal_b)) begin
                    accept     = 1'b1;
                    next_state = S_CLEAR;
                    load       = 1'b1;
                    load_val   = TW'(CLEAR_CYC - 1);
                end else if (start) begin
                    reject = 1'b1;
                end
            end
            S_CLEAR: begin
                if (expire) begin
                    next_state = S_SETTLE;
                    load       = 1'b1;
                    load_val   = TW'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (expire) begin
                    next_state = S_COUNT;
                    load       = 1'b1;
                    load_val   = TW'(WINDOW_CYC - 1);
                end
            end
            S_COUNT: begin
                if (expire) begin
                    next_state = S_SYNC;
                    load       = 1'b1;
                    load_val   = TW'(SYNC_CYC - 1);
                end
            end
            S_SYNC: begin
                if (expire) begin
                    next_state = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (last_bit) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_CLEAR;
                    load       = 1'b1;
                    load_val   = TW'(CLEAR_CYC - 1);
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Strobes are registered from next_state so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cfg_err    <= 1'b0;
            osc_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            resp_valid <= 1'b0;
            tie_seen   <= 1'b0;
            resp       <= '0;
            sel_a      <= '0;
            sel_b      <= '0;
            k          <= '0;
        end else begin
            state      <= next_state;
            cfg_err    <= reject;
            osc_en     <= (next_state == S_CLEAR) || (next_state == S_SETTLE) ||
                          (next_state == S_COUNT) || (next_state == S_SYNC) ||
                          (next_state == S_COMPARE);
            cnt_clr    <= (next_state == S_CLEAR);
            cnt_en     <= (next_state == S_COUNT);
            resp_valid <= (next_state == S_DONE);
            if (accept) begin
                sel_a    <= chal_a;
                sel_b    <= chal_b;
                resp     <= '0;
                k        <= '0;
                tie_seen <= 1'b0;
            end
            if (state == S_COMPARE) begin
                resp[k] <= (cnt_a > cnt_b);
                if (cnt_a == cnt_b) begin
                    tie_seen <= 1'b1;
                end
                // 5-bit selects wrap 31 -> 0 across the 32-oscillator bank.
                sel_a <= sel_a + SEL_W'(1);
                sel_b <= sel_b + SEL_W'(1);
                k     <= k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// tb/tb_puf_eval_sequencer.sv - self-checking bench for puf_eval_sequencer
module tb_puf_eval_sequencer;

    localparam int RB = 4;
    localparam int CW = 16;
    localparam int WC = 8;
    localparam int SC = 2;
    localparam int YC = 1;
    localparam int T  = 3 + SC + WC + YC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    chal_a = '0;
    logic [4:0]    chal_b = '0;
    logic          busy;
    logic          cfg_err;
    logic          osc_en;
    logic [4:0]    sel_a;
    logic [4:0]    sel_b;
    logic          cnt_clr;
    logic          cnt_en;
    logic [CW-1:0] cnt_a = '0;
    logic [CW-1:0] cnt_b = '0;
    logic [RB-1:0] resp;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic          tie_seen;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] va [RB];
    logic [CW-1:0] vb [RB];

    puf_eval_sequencer #(
        .RESP_BITS  (RB),
        .CNT_W      (CW),
        .WINDOW_CYC (WC),
        .SETTLE_CYC (SC),
        .SYNC_CYC   (YC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .chal_a     (chal_a),
        .chal_b     (chal_b),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .osc_en     (osc_en),
        .sel_a      (sel_a),
        .sel_b      (sel_b),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .resp       (resp),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .tie_seen   (tie_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {11'b0, busy, cfg_err, osc_en, cnt_clr, cnt_en, resp_valid, tie_seen,
                    resp, sel_a, sel_b}, 32'h0);
    endtask

    task automatic randomize_counts(input int tie_bit);
        for (int i = 0; i < RB; i++) begin
            va[i] = CW'($urandom_range(0, 65535));
            vb[i] = ($urandom_range(0, 3) == 0) ? va[i] : CW'($urandom_range(0, 65535));
        end
        if (tie_bit >= 0) begin
            vb[tie_bit] = va[tie_bit];
        end
    endtask

    // One run of RB bits; counts for bit k come from va[k]/vb[k] and are held over its whole span.
    task automatic run(input logic [4:0] ca, input logic [4:0] cb, input int ready_delay,
                       input bit mid_start, input int abort_c);
        logic [RB-1:0] exp_resp;
        logic          exp_tie;
        int            en_cnt;
        int            clr_cnt;
        int            k;
        exp_resp = '0;
        exp_tie  = 1'b0;
        for (int i = 0; i < RB; i++) begin
            exp_resp[i] = (va[i] > vb[i]);
            if (va[i] == vb[i]) exp_tie = 1'b1;
        end
        @(negedge clk);
        start  = 1'b1;
        chal_a = ca;
        chal_b = cb;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        en_cnt  = 0;
        clr_cnt = 0;
        for (int c = 1; c <= RB * T + 1; c++) begin
            k = (c - 1) / T;
            if (k < RB) begin
                cnt_a = va[k];
                cnt_b = vb[k];
            end
            if (c == abort_c) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_all_zero("reset_mid_run");
                rst_n = 1'b1;
                @(negedge clk);
                check_all_zero("idle_after_reset");
                return;
            end
            if (((c - 1) % T == 0) && (k < RB)) begin
                check("bit_start_busy_osc", {30'b0, busy, osc_en}, 32'h3);
                check("sel_a_bit_start", sel_a, (int'(ca) + k) % 32);
                check("sel_b_bit_start", sel_b, (int'(cb) + k) % 32);
            end
            if (cnt_en)  en_cnt++;
            if (cnt_clr) clr_cnt++;
            if ((c % T == 0) && (k < RB)) begin
                check("cnt_en_cycles", en_cnt, WC);
                check("cnt_clr_cycles", clr_cnt, 2);
                check("sel_a_compare", sel_a, (int'(ca) + k) % 32);
                check("sel_b_compare", sel_b, (int'(cb) + k) % 32);
                en_cnt  = 0;
                clr_cnt = 0;
            end
            if (c == RB * T) begin
                check("valid_before_done", resp_valid, 1'b0);
            end
            if (mid_start && c == 20) begin
                start  = 1'b1;
                chal_a = 5'd7;
                chal_b = 5'd7;
            end
            if (mid_start && c == 21) begin
                start = 1'b0;
                check("no_cfg_err_mid_run", cfg_err, 1'b0);
            end
            if (c < RB * T + 1) @(negedge clk);
        end
        check("valid_at_done", resp_valid, 1'b1);
        check("resp", resp, exp_resp);
        check("tie_seen", tie_seen, exp_tie);
        check("done_busy_osc", {30'b0, busy, osc_en}, 32'h2);
        for (int i = 0; i < ready_delay; i++) begin
            @(negedge clk);
            check("resp_hold", {resp_valid, resp}, {1'b1, exp_resp});
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("after_handshake", {30'b0, busy, resp_valid}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < RB; i++) begin
            va[i] = 16'd100;
            vb[i] = 16'd90;
        end
        run(5'd3, 5'd17, 0, 1'b0, 0);

        for (int i = 0; i < RB; i++) begin
            va[i] = 16'd100;
            vb[i] = (i % 2 == 1) ? 16'd90 : 16'd110;
        end
        run(5'd3, 5'd17, 0, 1'b0, 0);

        randomize_counts(-1);
        run(5'd30, 5'd0, 0, 1'b0, 0);

        @(negedge clk);
        start  = 1'b1;
        chal_a = 5'd5;
        chal_b = 5'd5;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", {30'b0, cfg_err, busy}, 32'h2);
        @(negedge clk);
        check("cfg_err_cleared", {30'b0, cfg_err, busy}, 32'h0);

        randomize_counts(2);
        run(5'd5, 5'd6, 20, 1'b1, 0);

        randomize_counts(-1);
        run(5'd1, 5'd2, 0, 1'b0, T + 6);

        for (int r = 0; r < 3; r++) begin
            logic [4:0] ca;
            logic [4:0] cb;
            ca = 5'($urandom_range(0, 31));
            cb = ca ^ 5'($urandom_range(1, 31));
            randomize_counts(-1);
            run(ca, cb, $urandom_range(0, 3), 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
